// File: rtl/dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder
//
// Data-memory responder for a small processor's memory stage. A single word
// address selects either a synchronous RAM or a handful of memory-mapped
// registers. Every read is registered, so q_dmem always lags the address by
// exactly one clock.
//
// Address map (word addresses):
//   0x0000 .. 2**ADDR_WIDTH-1  RAM. Read-first on a same-word write. Not reset.
//   0x1000  CYCLE       RO  free-running 32-bit cycle counter
//   0x1001  TIMER_LOAD  WO  loads the down-counter. Reads return 0.
//   0x1002  TIMER_CNT   RO  current down-counter value
//   0x1003  STATUS      RW1C bit0 = expired flag. Writing data[0]=1 clears it.
//   0x1004  GPIO_IN     RO  gpio_in after a 2-flop synchronizer
//   0x1005  LED         RW  8-bit LED register, mirrored on led_out
//   Any other address reads 0, and writes to it are dropped.
//
// Build option:
//   DMEM_MMIO_TIMER_EN  When defined, the down-counter, its FSM, STATUS and
//                       timer_irq are built. When undefined, 0x1001..0x1003
//                       read 0 and ignore writes, and timer_irq is tied low.
//
// Ports:
//   clock         single clock; all state updates on its rising edge
//   reset         asynchronous, active-high
//   address_dmem  word address from the memory stage
//   data          store data
//   wren          store strobe; the write happens on the edge where it is high
//   q_dmem        registered load data (one clock of latency)
//   gpio_in       asynchronous board switches and buttons
//   led_out       LED register contents
//   timer_irq     sticky timer-expired flag, driven straight from its register
//
// Bus handshake: there is no valid/ready pair. Every clock is a transfer.
// A read is implied on every cycle for the presented address. A write
// happens when wren=1. Neither one can stall.
// -----------------------------------------------------------------------------
module dmem_mmio_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  led_out,
  output logic        timer_irq
);

  localparam int          RAM_WORDS   = 2 ** ADDR_WIDTH;
  localparam logic [31:0] ADDR_CYCLE  = 32'h0000_1000;
  localparam logic [31:0] ADDR_GPIO   = 32'h0000_1004;
  localparam logic [31:0] ADDR_LED    = 32'h0000_1005;

  // Timer observation tap. It is kept as one packed struct so that an
  // assertion module can be bound to it without extra ports.
  typedef struct packed {
    logic        running;
    logic [31:0] count;
    logic        expired;
  } timer_dbg_t;

  timer_dbg_t timer_dbg;
  logic       unused_timer_dbg;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                  ram_hit;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  mmio_wr;
  logic                  led_wr;

  // RAM takes precedence. With ADDR_WIDTH<=12 the RAM window and the
  // 0x1000 MMIO block never overlap, so this ordering only matters for
  // oversized RAM builds.
  assign ram_hit = (address_dmem >> ADDR_WIDTH) == 32'd0;
  assign ram_idx = address_dmem[ADDR_WIDTH-1:0];
  assign mmio_wr = wren && !ram_hit;
  assign led_wr  = mmio_wr && (address_dmem == ADDR_LED);

  // ---------------------------------------------------------------------------
  // RAM array: no reset, written on the clock edge
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (wren && ram_hit) begin
      ram_mem[ram_idx] <= data;
    end
  end

  // ---------------------------------------------------------------------------
  // CYCLE counter, LED register, GPIO synchronizer, read data register
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_q, cycle_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [31:0] q_q, q_d;

  assign cycle_d = cycle_q + 32'd1;
  assign led_d   = led_wr ? data[7:0] : led_q;

`ifdef DMEM_MMIO_TIMER_EN
  // ---------------------------------------------------------------------------
  // Down-counter timer
  // ---------------------------------------------------------------------------
  localparam logic [31:0] ADDR_TLOAD  = 32'h0000_1001;
  localparam logic [31:0] ADDR_TCNT   = 32'h0000_1002;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1003;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_e;

  timer_state_e tstate_q;
  logic [31:0]  count_q;
  logic         expired_q;
  logic         load_wr;
  logic         status_clr;

  assign load_wr    = mmio_wr && (address_dmem == ADDR_TLOAD);
  assign status_clr = mmio_wr && (address_dmem == ADDR_STATUS) && data[0];

  // Two rules about same-clock events:
  //  - A STATUS clear is applied first. An expiry on the same clock then
  //    overrides it, because the last non-blocking assignment wins, so the
  //    set wins.
  //  - A LOAD write is checked before the 1->0 test. When both land on the
  //    same clock, the restart wins and the old count never raises expired.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tstate_q  <= T_IDLE;
      count_q   <= 32'd0;
      expired_q <= 1'b0;
    end else begin
      if (status_clr) begin
        expired_q <= 1'b0;
      end
      case (tstate_q)
        T_IDLE: begin
          if (load_wr) begin
            count_q  <= data;
            tstate_q <= (data != 32'd0) ? T_RUN : T_IDLE;
          end
        end
        T_RUN: begin
          if (load_wr) begin
            count_q  <= data;
            tstate_q <= (data != 32'd0) ? T_RUN : T_IDLE;
          end else if (count_q <= 32'd1) begin
            // Final decrement. The <= also catches a zero count, which
            // should never reach RUN.
            count_q   <= 32'd0;
            tstate_q  <= T_IDLE;
            expired_q <= 1'b1;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        default: begin
          tstate_q <= T_IDLE;
          count_q  <= 32'd0;
        end
      endcase
    end
  end

  assign timer_irq = expired_q;
  assign timer_dbg = '{running: (tstate_q == T_RUN), count: count_q, expired: expired_q};
`else
  assign timer_irq = 1'b0;
  assign timer_dbg = '0;
`endif

  assign unused_timer_dbg = ^timer_dbg;

  // ---------------------------------------------------------------------------
  // Read mux. The RAM word is read before this edge's write lands, which
  // gives read-first behaviour on a same-word read and write.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d = 32'd0;
    if (ram_hit) begin
      q_d = ram_mem[ram_idx];
    end else begin
      case (address_dmem)
        ADDR_CYCLE:  q_d = cycle_q;
`ifdef DMEM_MMIO_TIMER_EN
        ADDR_TCNT:   q_d = count_q;
        ADDR_STATUS: q_d = {31'd0, expired_q};
`endif
        ADDR_GPIO:   q_d = {24'd0, sync2_q};
        ADDR_LED:    q_d = {24'd0, led_q};
        default:     q_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q     <= 32'd0;
      cycle_q <= 32'd0;
      led_q   <= 8'd0;
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
    end else begin
      q_q     <= q_d;
      cycle_q <= cycle_d;
      led_q   <= led_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  assign q_dmem  = q_q;
  assign led_out = led_q;

endmodule
